// File: rtl/conv_pkg.sv
// Shared types and sizing for the convolution sequencer.
package conv_pkg;

    localparam int unsigned DATAWIDTH = 32;
    localparam int unsigned SIZEW     = 5;
    localparam int unsigned AW_IN     = 5;
    localparam int unsigned AW_OUT    = 6;

    // DCONFIG field offsets
    localparam int unsigned SX_LSB = 0;
    localparam int unsigned SY_LSB = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } conv_state_t;

    // X length field of a DCONFIG word
    function automatic logic [SIZEW-1:0] cfg_size_x(input logic [31:0] dcfg);
        return dcfg[SX_LSB +: SIZEW];
    endfunction

    // Y length field of a DCONFIG word
    function automatic logic [SIZEW-1:0] cfg_size_y(input logic [31:0] dcfg);
        return dcfg[SY_LSB +: SIZEW];
    endfunction

    // Index of the last output word, SX+SY-2 (max 60 fits AW_OUT bits)
    function automatic logic [AW_OUT-1:0] last_index(input logic [SIZEW-1:0] sx,
                                                     input logic [SIZEW-1:0] sy);
        return AW_OUT'(sx) + AW_OUT'(sy) - AW_OUT'(2);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate datapath: product of the previous cycle's read data is
// added into the accumulator; everything freezes while en_s is low.
module conv_mac
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 en_s,
    input  logic                 clr,
    input  logic                 rd_en,
    input  logic [DATAWIDTH-1:0] data_x,
    input  logic [DATAWIDTH-1:0] data_y,
    output logic [DATAWIDTH-1:0] acc
);

    logic                 valid_q, valid_d;
    logic [DATAWIDTH-1:0] acc_q, acc_d;
    logic [DATAWIDTH-1:0] prod;

    // Truncated product; the memories hold their data while stalled
    assign prod = data_x * data_y;

    // Next valid / accumulator value
    always_comb begin
        valid_d = rd_en;
        acc_d   = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (valid_q) begin
            acc_d = acc_q + prod;
        end
    end

    // Datapath registers, held while disabled
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
        end else if (en_s) begin
            valid_q <= valid_d;
            acc_q   <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks X/Y taps for each output index, accumulates
// through conv_mac and writes one MEMZ word per output, then pulses done.
module conv_seq_ctrl
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 en_s,
    input  logic                 start,
    input  logic [SIZEW-1:0]     size_x,
    input  logic [SIZEW-1:0]     size_y,
    output logic                 rd_en,
    output logic [AW_IN-1:0]     addr_x,
    output logic [AW_IN-1:0]     addr_y,
    input  logic [DATAWIDTH-1:0] data_x,
    input  logic [DATAWIDTH-1:0] data_y,
    output logic                 wr_en_z,
    output logic [AW_OUT-1:0]    addr_z,
    output logic [DATAWIDTH-1:0] data_z,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned NW = AW_OUT + 1;

    conv_state_t          state_q, state_d;
    logic [SIZEW-1:0]     sx_q, sx_d;
    logic [SIZEW-1:0]     sy_q, sy_d;
    logic [AW_OUT-1:0]    n_q, n_d;
    logic [AW_IN-1:0]     k_q, k_d;
    logic [AW_IN-1:0]     kend_q, kend_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 rd_en_q, rd_en_d;
    logic [AW_IN-1:0]     addr_x_q, addr_x_d;
    logic [AW_IN-1:0]     addr_y_q, addr_y_d;
    logic                 wr_en_q, wr_en_d;
    logic [AW_OUT-1:0]    addr_z_q, addr_z_d;

    logic [NW-1:0]        n_plus1;
    logic [NW-1:0]        sy_ext;
    logic [AW_OUT-1:0]    sx_m1;
    logic [AW_IN-1:0]     k_start;
    logic [AW_IN-1:0]     k_stop;
    logic [AW_IN-1:0]     k_next;
    logic [AW_OUT-1:0]    last_n;
    logic                 acc_clr;

    // Tap bounds for output n: k from max(0, n-SY+1) to min(n, SX-1)
    assign n_plus1 = NW'(n_q) + NW'(1);
    assign sy_ext  = NW'(sy_q);
    assign k_start = (n_plus1 > sy_ext) ? AW_IN'(n_plus1 - sy_ext) : '0;
    assign sx_m1   = AW_OUT'(sx_q) - AW_OUT'(1);
    assign k_stop  = (n_q < sx_m1) ? AW_IN'(n_q) : AW_IN'(sx_m1);
    assign k_next  = k_q + AW_IN'(1);
    assign last_n  = last_index(sx_q, sy_q);

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        n_d      = n_q;
        k_d      = k_q;
        kend_d   = kend_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rd_en_d  = 1'b0;
        addr_x_d = addr_x_q;
        addr_y_d = addr_y_q;
        wr_en_d  = 1'b0;
        addr_z_d = addr_z_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sx_d = size_x;
                    sy_d = size_y;
                    if ((size_x == '0) || (size_y == '0)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = INIT;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        n_d     = '0;
                    end
                end
            end
            INIT: begin
                state_d  = READ;
                k_d      = k_start;
                kend_d   = k_stop;
                rd_en_d  = 1'b1;
                addr_x_d = k_start;
                addr_y_d = AW_IN'(n_q - AW_OUT'(k_start));
            end
            READ: begin
                if (k_q == kend_q) begin
                    state_d = DRAIN;
                end else begin
                    k_d      = k_next;
                    rd_en_d  = 1'b1;
                    addr_x_d = k_next;
                    addr_y_d = AW_IN'(n_q - AW_OUT'(k_next));
                end
            end
            DRAIN: begin
                state_d  = WRITE;
                wr_en_d  = 1'b1;
                addr_z_d = n_q;
            end
            WRITE: begin
                if (n_q == last_n) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = INIT;
                    n_d     = n_q + AW_OUT'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; en_s low freezes everything
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q  <= IDLE;
            sx_q     <= '0;
            sy_q     <= '0;
            n_q      <= '0;
            k_q      <= '0;
            kend_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_x_q <= '0;
            addr_y_q <= '0;
            wr_en_q  <= 1'b0;
            addr_z_q <= '0;
        end else if (en_s) begin
            state_q  <= state_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            n_q      <= n_d;
            k_q      <= k_d;
            kend_q   <= kend_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            addr_x_q <= addr_x_d;
            addr_y_q <= addr_y_d;
            wr_en_q  <= wr_en_d;
            addr_z_q <= addr_z_d;
        end
    end

    // Accumulator restarts at the top of each output word
    assign acc_clr = (state_q == INIT);

    conv_mac u_mac (
        .clk    (clk),
        .rst_a  (rst_a),
        .en_s   (en_s),
        .clr    (acc_clr),
        .rd_en  (rd_en),
        .data_x (data_x),
        .data_y (data_y),
        .acc    (data_z)
    );

    // Memory strobes are suppressed while stalled so MEMX/MEMY keep their data
    assign rd_en   = rd_en_q & en_s;
    assign wr_en_z = wr_en_q & en_s;
    assign addr_x  = addr_x_q;
    assign addr_y  = addr_y_q;
    assign addr_z  = addr_z_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl with behavioural MEMX/MEMY/MEMZ.
module tb_conv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        en_s;
    logic        start;
    logic [4:0]  size_x;
    logic [4:0]  size_y;
    logic        rd_en;
    logic [4:0]  addr_x;
    logic [4:0]  addr_y;
    logic [31:0] data_x = '0;
    logic [31:0] data_y = '0;
    logic        wr_en_z;
    logic [5:0]  addr_z;
    logic [31:0] data_z;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] memx [32];
    logic [31:0] memy [32];
    logic [31:0] memz [64];
    int          memz_gen [64];
    logic [31:0] exp_z [64];

    int n_cmp   = 0;
    int n_bad   = 0;
    int run_id  = 0;
    int rd_total = 0;
    int wr_total = 0;
    int max_az  = 0;

    always #5 clk = ~clk;

    conv_seq_ctrl dut (
        .clk     (clk),
        .rst_a   (rst_a),
        .en_s    (en_s),
        .start   (start),
        .size_x  (size_x),
        .size_y  (size_y),
        .rd_en   (rd_en),
        .addr_x  (addr_x),
        .addr_y  (addr_y),
        .data_x  (data_x),
        .data_y  (data_y),
        .wr_en_z (wr_en_z),
        .addr_z  (addr_z),
        .data_z  (data_z),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    // Synchronous RAM models: one-cycle read latency, output held when idle
    always @(posedge clk) begin
        if (rd_en) begin
            data_x   <= memx[addr_x];
            data_y   <= memy[addr_y];
            rd_total <= rd_total + 1;
        end
        if (wr_en_z) begin
            memz[addr_z]     <= data_z;
            memz_gen[addr_z] <= run_id;
            wr_total         <= wr_total + 1;
            if (int'(addr_z) > max_az) max_az <= int'(addr_z);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Golden convolution, products and sums wrap at 32 bits
    task automatic model(input int sx, input int sy);
        for (int n = 0; n < 64; n++) begin
            logic [31:0] acc;
            acc = '0;
            for (int k = 0; k < sx; k++) begin
                if ((n - k >= 0) && (n - k < sy)) acc = acc + memx[k] * memy[n-k];
            end
            exp_z[n] = acc;
        end
    endtask

    // Compare the first cnt MEMZ words written in the current run
    task automatic check_z(input string pfx, input int cnt);
        for (int n = 0; n < cnt; n++) begin
            logic [31:0] got;
            got = (memz_gen[n] == run_id) ? memz[n] : 32'hDEAD_BEEF;
            check_eq($sformatf("%s z[%0d]", pfx, n), 64'(got), 64'(exp_z[n]));
        end
    endtask

    // Pulse start, then watch for done with optional stall, glitch start, abort
    task automatic do_run(input int sx, input int sy, input int drop_at, input int drop_len,
                          input int glitch_at, input int abort_at,
                          output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        run_id++;
        @(negedge clk);
        size_x = 5'(sx);
        size_y = 5'(sy);
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
            if (i == abort_at) begin
                rst_a = 1'b0;
                break;
            end
            if (i == drop_at) en_s = 1'b0;
            if (i == drop_at + drop_len) en_s = 1'b1;
            if (i == glitch_at) begin
                start  = 1'b1;
                size_x = 5'd1;
                size_y = 5'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic load_case1();
        for (int i = 0; i < 32; i++) begin
            memx[i] = '0;
            memy[i] = '0;
        end
        memx[0] = 32'd1; memx[1] = 32'd2; memx[2] = 32'd3;
        memy[0] = 32'd4; memy[1] = 32'd5;
        exp_z[0] = 32'd4; exp_z[1] = 32'd13; exp_z[2] = 32'd22; exp_z[3] = 32'd15;
    endtask

    initial begin
        int lat;
        int bcnt;
        int rd0;
        int wr0;
        int dcnt;

        for (int i = 0; i < 64; i++) memz_gen[i] = 0;
        rst_a  = 1'b0;
        en_s   = 1'b1;
        start  = 1'b0;
        size_x = '0;
        size_y = '0;
        repeat (3) @(negedge clk);
        check_eq("reset busy",    64'(busy),    64'd0);
        check_eq("reset done",    64'(done),    64'd0);
        check_eq("reset err",     64'(err),     64'd0);
        check_eq("reset rd_en",   64'(rd_en),   64'd0);
        check_eq("reset wr_en_z", 64'(wr_en_z), 64'd0);
        check_eq("reset data_z",  64'(data_z),  64'd0);
        rst_a = 1'b1;

        // Case 1: x=[1,2,3], y=[4,5]
        load_case1();
        wr0 = wr_total;
        do_run(3, 2, -1, 0, -1, -1, lat, bcnt);
        check_z("c1", 4);
        check_eq("c1 latency", 64'(lat),  64'd19);
        check_eq("c1 busy",    64'(bcnt), 64'd18);
        check_eq("c1 writes",  64'(wr_total - wr0), 64'd4);
        check_eq("c1 err",     64'(err),  64'd0);

        // Case 2: SX=5, SY=10 random data
        for (int i = 0; i < 32; i++) begin
            memx[i] = 32'($urandom_range(0, 99));
            memy[i] = 32'($urandom_range(0, 99));
        end
        model(5, 10);
        rd0 = rd_total;
        do_run(5, 10, -1, 0, -1, -1, lat, bcnt);
        check_z("c2", 14);
        check_eq("c2 latency", 64'(lat), 64'd93);
        check_eq("c2 reads",   64'(rd_total - rd0), 64'd50);

        // Case 3: single tap
        memx[0] = 32'd7;
        memy[0] = 32'd6;
        exp_z[0] = 32'd42;
        wr0 = wr_total;
        do_run(1, 1, -1, 0, -1, -1, lat, bcnt);
        check_z("c3", 1);
        check_eq("c3 latency", 64'(lat), 64'd5);
        check_eq("c3 writes",  64'(wr_total - wr0), 64'd1);

        // Case 4: zero size flags err, then a valid start clears it
        wr0 = wr_total;
        do_run(0, 3, -1, 0, -1, -1, lat, bcnt);
        check_eq("c4 latency", 64'(lat), 64'd1);
        check_eq("c4 busy",    64'(bcnt), 64'd0);
        check_eq("c4 err",     64'(err), 64'd1);
        check_eq("c4 writes",  64'(wr_total - wr0), 64'd0);
        do_run(1, 1, -1, 0, -1, -1, lat, bcnt);
        check_eq("c4 err cleared", 64'(err), 64'd0);
        check_z("c4b", 1);

        // Case 5: four-cycle stall in the middle of READ
        load_case1();
        do_run(3, 2, 5, 4, -1, -1, lat, bcnt);
        check_z("c5", 4);
        check_eq("c5 latency", 64'(lat), 64'd23);

        // Case 6: reset during WRITE of n=1, then rerun with a start while busy
        wr0 = wr_total;
        do_run(3, 2, -1, 0, -1, 8, lat, bcnt);
        repeat (2) @(negedge clk);
        check_eq("c6 busy in reset",  64'(busy),    64'd0);
        check_eq("c6 wr_en in reset", 64'(wr_en_z), 64'd0);
        rst_a = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check_eq("c6 no done",   64'(dcnt), 64'd0);
        check_eq("c6 writes",    64'(wr_total - wr0), 64'd1);
        check_eq("c6 z[1] kept", 64'(memz_gen[1] == run_id), 64'd0);
        do_run(3, 2, -1, 0, 6, -1, lat, bcnt);
        check_z("c6", 4);
        check_eq("c6 latency", 64'(lat), 64'd19);

        // Case 7: maximum sizes, all-ones data wraps
        for (int i = 0; i < 32; i++) begin
            memx[i] = 32'hFFFF_FFFF;
            memy[i] = 32'hFFFF_FFFF;
        end
        model(31, 31);
        do_run(31, 31, -1, 0, -1, -1, lat, bcnt);
        check_z("c7", 61);
        check_eq("c7 latency",  64'(lat), 64'd1145);
        check_eq("c7 max addr", 64'(max_az), 64'd60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
